// File: rtl/sram_bus_slave_pkg.sv
// sram_bus_slave_pkg: bus query request/response types and slave FSM state encoding
package sram_bus_slave_pkg;
  localparam int BUS_MAX_BEATS = 15;
  localparam int BEAT_W = $clog2(BUS_MAX_BEATS + 1);
  typedef enum logic [1:0] {SLV_IDLE, SLV_WR_DATA, SLV_WR_RESP, SLV_RD_DATA} bus_slave_state_t;
  typedef struct packed {
    logic              awvalid;
    logic [31:0]       awaddr;
    logic [BEAT_W-1:0] wlen;
    logic              wvalid;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              bready;
    logic              arvalid;
    logic [31:0]       araddr;
    logic [BEAT_W-1:0] rlen;
    logic              rready;
  } bus_query_req_t;
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic        rready;
    logic        rvalid;
    logic        rlast;
    logic [31:0] rdata;
  } bus_query_resp_t;
endpackage

// File: rtl/sram_bus_slave.sv
// sram_bus_slave: burst read/write bus slave driving a single-port synchronous SRAM
module sram_bus_slave
  import sram_bus_slave_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  bus_query_req_t    req,
  output bus_query_resp_t   resp,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  bus_slave_state_t  state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [BEAT_W-1:0] len, len_n, cnt, cnt_n;
  logic              last;
  logic              unused_bits;
  assign unused_bits = ^{req.wlast, req.awaddr[31:ADDR_W+2], req.awaddr[1:0],
                         req.araddr[31:ADDR_W+2], req.araddr[1:0]};
  assign last = cnt == len;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLV_IDLE;
      addr  <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      len   <= len_n;
      cnt   <= cnt_n;
    end
  end
  always_comb begin
    state_n    = state;
    addr_n     = addr;
    len_n      = len;
    cnt_n      = cnt;
    resp       = '0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = addr;
    sram_be    = '0;
    sram_wdata = '0;
    case (state)
      SLV_IDLE: begin
        if (req.awvalid && req.wlen != '0) begin
          resp.awready = 1'b1;
          addr_n       = req.awaddr[ADDR_W+1:2];
          len_n        = req.wlen;
          cnt_n        = BEAT_W'(1);
          state_n      = SLV_WR_DATA;
        end else if (req.arvalid && req.rlen != '0) begin
          // first word is fetched in the accept cycle so data is ready one cycle later
          resp.rready = 1'b1;
          sram_ce     = 1'b1;
          sram_addr   = req.araddr[ADDR_W+1:2];
          addr_n      = req.araddr[ADDR_W+1:2];
          len_n       = req.rlen;
          cnt_n       = BEAT_W'(1);
          state_n     = SLV_RD_DATA;
        end
      end
      SLV_WR_DATA: begin
        resp.wready = req.wvalid;
        if (req.wvalid) begin
          sram_ce    = 1'b1;
          sram_we    = 1'b1;
          sram_be    = req.wstrb;
          sram_wdata = req.wdata;
          addr_n     = addr + 1'b1;
          cnt_n      = last ? cnt : cnt + 1'b1;
          state_n    = last ? SLV_WR_RESP : SLV_WR_DATA;
        end
      end
      SLV_WR_RESP: begin
        resp.bvalid = 1'b1;
        state_n     = req.bready ? SLV_IDLE : SLV_WR_RESP;
      end
      SLV_RD_DATA: begin
        // while stalled the SRAM is left idle so it keeps presenting the current word
        resp.rvalid = 1'b1;
        resp.rdata  = sram_rdata;
        resp.rlast  = last;
        if (req.rready) begin
          state_n = last ? SLV_IDLE : SLV_RD_DATA;
          if (!last) begin
            sram_ce   = 1'b1;
            sram_addr = addr + 1'b1;
            addr_n    = addr + 1'b1;
            cnt_n     = cnt + 1'b1;
          end
        end
      end
      default: state_n = SLV_IDLE;
    endcase
    if (rst) begin
      resp       = '0;
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_be    = '0;
      sram_wdata = '0;
    end
  end
endmodule
